// File: rtl/vga_pkg.sv
// Shared types and constants for the line-buffer video path.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        StSync  = 2'd0,
        StPaint = 2'd1,
        StCopy  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; priority starts one above ptr and wraps.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // Upper segment above ptr first, then wrap to the low segment.
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i > int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i <= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/scanline_sched.sv
// Per-field scanline scheduler: paint phase with round-robin line-buffer writes,
// then a copy phase handing the line to the copy engine.
module scanline_sched
    import vga_pkg::*;
#(
    parameter int unsigned NUM_PAINTERS = 4,
    parameter int unsigned LINES        = 480,
    parameter int unsigned LINE_W       = 9,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             vsync,
    input  logic [NUM_PAINTERS-1:0]          pnt_en,
    input  logic [NUM_PAINTERS-1:0]          pnt_req,
    input  logic [NUM_PAINTERS*ADDR_W-1:0]   pnt_addr,
    input  logic [NUM_PAINTERS*DATA_W-1:0]   pnt_data,
    output logic [NUM_PAINTERS-1:0]          pnt_gnt,
    input  logic [NUM_PAINTERS-1:0]          pnt_done,
    output logic [NUM_PAINTERS-1:0]          paint_start,
    output logic [LINE_W-1:0]                paint_line,
    output logic                             lb_we,
    output logic [ADDR_W-1:0]                lb_addr,
    output logic [DATA_W-1:0]                lb_data,
    output logic                             copy_start,
    input  logic                             copy_done,
    output logic                             frame_done,
    output logic                             overrun
);

    localparam int unsigned IDX_W = (NUM_PAINTERS > 1) ? $clog2(NUM_PAINTERS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PAINTERS - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);

    sched_state_t state_q, state_d;

    logic [LINE_W-1:0]       line_q, line_d;
    logic [1:0]              cnt_q, cnt_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [NUM_PAINTERS-1:0] start_q, start_d;
    logic                    copy_start_q, copy_start_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q, overrun_d;
    logic                    lb_we_q, lb_we_d;
    logic [ADDR_W-1:0]       lb_addr_q, lb_addr_d;
    logic [DATA_W-1:0]       lb_data_q, lb_data_d;

    logic [NUM_PAINTERS-1:0] live_req;
    logic [NUM_PAINTERS-1:0] arb_req;
    logic [IDX_W-1:0]        arb_idx;
    logic                    all_done;
    logic                    exit_ok;
    logic                    last_line;

    assign live_req  = pnt_req & pnt_en;
    assign arb_req   = (state_q == StPaint) ? live_req : '0;
    assign all_done  = &(pnt_done | ~pnt_en);
    assign last_line = (line_q == LAST_LINE);
    // Dones are stale for the first two cycles of a line; cnt_q saturates at 2.
    assign exit_ok   = (cnt_q == 2'd2) && all_done && !(|live_req);

    rr_arbiter #(
        .N     (NUM_PAINTERS),
        .IDX_W (IDX_W)
    ) u_arb (
        .req (arb_req),
        .ptr (last_q),
        .gnt (pnt_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        start_d      = '0;
        copy_start_d = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = overrun_q;
        lb_we_d      = |pnt_gnt;
        lb_addr_d    = lb_addr_q;
        lb_data_d    = lb_data_q;

        if (|pnt_gnt) begin
            last_d = arb_idx;
        end
        for (int i = 0; i < NUM_PAINTERS; i++) begin
            if (pnt_gnt[i]) begin
                lb_addr_d = pnt_addr[i*ADDR_W +: ADDR_W];
                lb_data_d = pnt_data[i*DATA_W +: DATA_W];
            end
        end

        unique case (state_q)
            StSync: begin
            end
            StPaint: begin
                if (cnt_q != 2'd2) begin
                    cnt_d = cnt_q + 2'd1;
                end
                if (exit_ok) begin
                    state_d      = StCopy;
                    copy_start_d = 1'b1;
                end
            end
            StCopy: begin
                if (copy_done) begin
                    if (last_line) begin
                        frame_done_d = 1'b1;
                        state_d      = StSync;
                    end else begin
                        line_d  = line_q + LINE_W'(1);
                        cnt_d   = 2'd0;
                        start_d = pnt_en;
                        state_d = StPaint;
                    end
                end
            end
            default: state_d = StSync;
        endcase

        // vsync always restarts the field; outside SYNC it is an overrun.
        // frame_done set above survives so a coincident last copy still reports.
        if (vsync) begin
            state_d      = StPaint;
            line_d       = '0;
            cnt_d        = 2'd0;
            start_d      = pnt_en;
            copy_start_d = 1'b0;
            if (state_q != StSync) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StSync;
            line_q       <= '0;
            cnt_q        <= 2'd0;
            last_q       <= LAST_IDX;
            start_q      <= '0;
            copy_start_q <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            lb_we_q      <= 1'b0;
            lb_addr_q    <= '0;
            lb_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            start_q      <= start_d;
            copy_start_q <= copy_start_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            lb_we_q      <= lb_we_d;
            lb_addr_q    <= lb_addr_d;
            lb_data_q    <= lb_data_d;
        end
    end

    assign paint_start = start_q;
    assign paint_line  = line_q;
    assign copy_start  = copy_start_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;
    assign lb_we       = lb_we_q;
    assign lb_addr     = lb_addr_q;
    assign lb_data     = lb_data_q;

endmodule

// File: tb/tb_scanline_sched.sv
// Bench for scanline_sched: directed scenarios plus randomized traffic against a
// behavioural model of the scheduling rules.
module tb_scanline_sched;

    localparam int NP    = 4;
    localparam int LINES = 4;
    localparam int LW    = 3;
    localparam int AW    = 10;
    localparam int DW    = 16;

    logic             clk;
    logic             rst_n;
    logic             vsync;
    logic [NP-1:0]    pnt_en;
    logic [NP-1:0]    pnt_req;
    logic [NP*AW-1:0] pnt_addr;
    logic [NP*DW-1:0] pnt_data;
    logic [NP-1:0]    pnt_gnt;
    logic [NP-1:0]    pnt_done;
    logic [NP-1:0]    paint_start;
    logic [LW-1:0]    paint_line;
    logic             lb_we;
    logic [AW-1:0]    lb_addr;
    logic [DW-1:0]    lb_data;
    logic             copy_start;
    logic             copy_done;
    logic             frame_done;
    logic             overrun;

    scanline_sched #(
        .NUM_PAINTERS (NP),
        .LINES        (LINES),
        .LINE_W       (LW),
        .ADDR_W       (AW),
        .DATA_W       (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vsync       (vsync),
        .pnt_en      (pnt_en),
        .pnt_req     (pnt_req),
        .pnt_addr    (pnt_addr),
        .pnt_data    (pnt_data),
        .pnt_gnt     (pnt_gnt),
        .pnt_done    (pnt_done),
        .paint_start (paint_start),
        .paint_line  (paint_line),
        .lb_we       (lb_we),
        .lb_addr     (lb_addr),
        .lb_data     (lb_data),
        .copy_start  (copy_start),
        .copy_done   (copy_done),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=sync 1=paint 2=copy, plus expected registered outputs.
    int            m_ph, m_line, m_pcyc, m_last;
    logic          m_ovr;
    logic          e_we, e_cstart, e_fdone;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [NP-1:0] e_start;

    function automatic int rr_pick(input logic [NP-1:0] r, input int last);
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (last + k) % NP;
            if (r[p]) return p;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : cmp
        int            g;
        logic [NP-1:0] eg;
        logic [NP-1:0] live;
        if (!rst_n) begin
            m_ph = 0; m_line = 0; m_pcyc = 0; m_last = NP - 1; m_ovr = 1'b0;
            e_we = 1'b0; e_addr = '0; e_data = '0; e_start = '0;
            e_cstart = 1'b0; e_fdone = 1'b0;
        end
        live = pnt_req & pnt_en;
        g    = (m_ph == 1) ? rr_pick(live, m_last) : -1;
        eg   = (g >= 0) ? NP'(1 << g) : '0;
        check("pnt_gnt",     32'(pnt_gnt),     32'(eg));
        check("lb_we",       32'(lb_we),       32'(e_we));
        check("lb_addr",     32'(lb_addr),     32'(e_addr));
        check("lb_data",     32'(lb_data),     32'(e_data));
        check("paint_start", 32'(paint_start), 32'(e_start));
        check("paint_line",  32'(paint_line),  32'(m_line));
        check("copy_start",  32'(copy_start),  32'(e_cstart));
        check("frame_done",  32'(frame_done),  32'(e_fdone));
        check("overrun",     32'(overrun),     32'(m_ovr));
        if (rst_n) begin
            e_we = (g >= 0);
            if (g >= 0) begin
                e_addr = pnt_addr[g*AW +: AW];
                e_data = pnt_data[g*DW +: DW];
                m_last = g;
            end
            e_start  = '0;
            e_cstart = 1'b0;
            e_fdone  = (m_ph == 2) && copy_done && (m_line == LINES - 1);
            if (vsync) begin
                if (m_ph != 0) m_ovr = 1'b1;
                m_ph = 1; m_line = 0; m_pcyc = 0; e_start = pnt_en;
            end else if (m_ph == 1) begin
                if (m_pcyc >= 2 && (&(pnt_done | ~pnt_en)) && live == '0) begin
                    m_ph = 2; e_cstart = 1'b1;
                end
                m_pcyc++;
            end else if (m_ph == 2 && copy_done) begin
                if (m_line == LINES - 1) m_ph = 0;
                else begin
                    m_line++; m_ph = 1; m_pcyc = 0; e_start = pnt_en;
                end
            end
        end
    end

    logic [NP-1:0] gnt_seen;
    always @(negedge clk) gnt_seen <= pnt_gnt;

    // Stimulus agents: mode 1 = single 3-pixel painter, mode 2 = random traffic.
    int mode, rem, cd_timer, rcyc;

    task automatic bfm_step();
        copy_done = 1'b0;
        if (cd_timer > 0) begin
            cd_timer--;
            if (cd_timer == 0) copy_done = 1'b1;
        end
        if (copy_start) cd_timer = (mode == 1) ? 5 : int'($urandom_range(1, 4));
        if (mode == 1) begin
            if (paint_start[0]) begin
                rem = 3; pnt_req[0] = 1'b1; pnt_done[0] = 1'b0;
            end else if (gnt_seen[0] && rem > 0) begin
                pnt_addr[AW-1:0] = pnt_addr[AW-1:0] + AW'(1);
                pnt_data[DW-1:0] = pnt_data[DW-1:0] + DW'(3);
                rem--;
                if (rem == 0) begin
                    pnt_req[0] = 1'b0; pnt_done[0] = 1'b1;
                end
            end
        end else begin
            if (rcyc % 64 == 0) pnt_en = NP'($urandom);
            rcyc++;
            pnt_req  = NP'($urandom & $urandom & $urandom);
            pnt_done = NP'(~($urandom & $urandom));
            for (int i = 0; i < NP; i++) begin
                pnt_addr[i*AW +: AW] = AW'($urandom);
                pnt_data[i*DW +: DW] = DW'($urandom);
            end
            vsync = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) copy_done = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (mode != 0) bfm_step();
    endtask

    logic [AW-1:0] paddr [NP];
    logic [DW-1:0] pdata [NP];
    int            ps, cs, fd;
    logic [11:0]   line_log;

    initial begin
        mode = 0; rem = 0; cd_timer = 0; rcyc = 0;
        rst_n = 1'b0; vsync = 1'b0; pnt_en = '0; pnt_req = '0; pnt_addr = '0;
        pnt_data = '0; pnt_done = '0; copy_done = 1'b0;
        paddr = '{10'h001, 10'h102, 10'h203, 10'h304};
        pdata = '{16'hA000, 16'hB111, 16'hC222, 16'hD333};
        #1;
        check("rst_gnt", 32'(pnt_gnt), 32'h0);
        check("rst_we", 32'(lb_we), 32'h0);
        check("rst_line", 32'(paint_line), 32'h0);
        check("rst_start", 32'(paint_start), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        tick(); tick();
        rst_n = 1'b1;

        // Round robin: all four request continuously.
        pnt_en = 4'hF; pnt_req = 4'hF;
        for (int i = 0; i < NP; i++) begin
            pnt_addr[i*AW +: AW] = paddr[i];
            pnt_data[i*DW +: DW] = pdata[i];
        end
        vsync = 1'b1; tick(); vsync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_gnt", 32'(pnt_gnt), 32'(4'b0001 << (k % 4)));
            if (k > 0) begin
                check("rr_addr", 32'(lb_addr), 32'(paddr[(k - 1) % 4]));
                check("rr_data", 32'(lb_data), 32'(pdata[(k - 1) % 4]));
            end
            tick();
        end

        // Sparse: only 1 and 3 after painter 1 was last granted.
        pnt_req = 4'b0010;
        @(negedge clk);
        check("sp_gnt1", 32'(pnt_gnt), 32'h2);
        tick();
        pnt_req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sp_gnt", 32'(pnt_gnt), (k % 2 == 0) ? 32'h8 : 32'h2);
            tick();
        end

        // Stale done: dones held across paint_start must not end the line early.
        pnt_req = '0; pnt_done = 4'hF;
        @(negedge clk);
        tick();
        copy_done = 1'b1;
        @(negedge clk);
        check("st_cs0", 32'(copy_start), 32'h1);
        tick();
        copy_done = 1'b0;
        @(negedge clk);
        check("st_ps", 32'(paint_start), 32'hF);
        check("st_line", 32'(paint_line), 32'h1);
        tick();
        pnt_done = '0;
        @(negedge clk);
        check("st_early", 32'(copy_start), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            check("st_wait", 32'(copy_start), 32'h0);
        end
        tick();
        pnt_done = 4'hF;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("st_late", 32'(copy_start), 32'h1);

        // Mid-field vsync during COPY of line 2.
        tick();
        copy_done = 1'b1; tick(); copy_done = 1'b0;
        tick(); tick(); tick();
        vsync = 1'b1;
        @(negedge clk);
        check("mf_cs", 32'(copy_start), 32'h1);
        check("mf_line2", 32'(paint_line), 32'h2);
        tick();
        vsync = 1'b0;
        @(negedge clk);
        check("mf_ovr", 32'(overrun), 32'h1);
        check("mf_line0", 32'(paint_line), 32'h0);
        check("mf_ps", 32'(paint_start), 32'hF);
        check("mf_fd", 32'(frame_done), 32'h0);

        // Reset while grants are flowing.
        tick();
        pnt_done = '0; pnt_req = 4'hF;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rm_we", 32'(lb_we), 32'h0);
        check("rm_gnt", 32'(pnt_gnt), 32'h0);
        check("rm_addr", 32'(lb_addr), 32'h0);
        check("rm_ovr", 32'(overrun), 32'h0);
        tick();
        rst_n = 1'b1; vsync = 1'b1;
        tick();
        vsync = 1'b0;
        @(negedge clk);
        check("rm_first", 32'(pnt_gnt), 32'h1);
        tick();

        // Field walk: one painter, 3 pixels per line, copy latency 5.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        pnt_en = 4'h1; pnt_req = '0; pnt_done = '0; copy_done = 1'b0;
        pnt_addr = '0; pnt_data = '0; cd_timer = 0; mode = 1;
        vsync = 1'b1; tick(); vsync = 1'b0;
        ps = 0; cs = 0; fd = 0; line_log = '0;
        for (int c = 0; c < 400 && fd == 0; c++) begin
            @(negedge clk);
            if (paint_start[0]) begin
                ps++;
                line_log = {line_log[8:0], paint_line};
            end
            if (copy_start) cs++;
            if (frame_done) fd++;
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (paint_start[0]) ps++;
            tick();
        end
        check("fw_frame_done", 32'(fd), 32'd1);
        check("fw_paint_starts", 32'(ps), 32'd4);
        check("fw_copy_starts", 32'(cs), 32'd4);
        check("fw_lines", 32'(line_log), 32'h053);

        // Randomized traffic, checked cycle by cycle against the model.
        mode = 2;
        for (int c = 0; c < 3000; c++) tick();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
